fetch_stage: RTL

- Instruction fetch stage; sits directly upstream of the decode stage and fills the decode pipeline register with valid/pc/insn.
- Owns the PC. Issues one outstanding request at a time to the instruction-memory port.
- Holds its output under decode stall via a one-entry skid buffer. Redirects (branch/jump from execute) flush all fetched state.

---
 rtl/fetch_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and single-outstanding instruction fetcher feeding decode,
// with a one-entry skid buffer for decode stalls and redirect flushing.
module fetch_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSN_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INSN_WIDTH-1:0] imem_resp_data,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INSN_WIDTH-1:0] out_insn
);
    typedef enum logic [1:0] {REQ, WAIT, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
    logic                    out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic [INSN_WIDTH-1:0]   out_insn_q, out_insn_d;
    logic                    buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0]   buf_pc_q, buf_pc_d;
    logic [INSN_WIDTH-1:0]   buf_insn_q, buf_insn_d;
    logic                    resp_take;

    assign imem_req_valid = !rst && state_q == REQ && !buf_valid_q && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_insn       = out_insn_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_insn_d    = out_insn_q;
        buf_valid_d   = buf_valid_q;
        buf_pc_d      = buf_pc_q;
        buf_insn_d    = buf_insn_q;
        resp_take     = state_q == WAIT && imem_resp_valid && !redirect_valid;
        if (redirect_valid) begin
            pc_d        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            out_valid_d = 1'b0;
            buf_valid_d = 1'b0;
            // An outstanding request must still retire its response, which is dropped
            state_d     = (state_q != REQ && imem_resp_valid) ? REQ : (state_q == WAIT ? DRAIN : state_q);
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + ADDR_WIDTH'(4);
                state_d       = WAIT;
            end else if (state_q != REQ && imem_resp_valid) begin
                state_d = REQ;
            end
            if (!stall || !out_valid_q) begin
                buf_valid_d = 1'b0;
                if (buf_valid_q) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = buf_pc_q;
                    out_insn_d  = buf_insn_q;
                end else if (resp_take) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = inflight_pc_q;
                    out_insn_d  = imem_resp_data;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (resp_take) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = inflight_pc_q;
                buf_insn_d  = imem_resp_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_insn_q    <= '0;
            buf_valid_q   <= 1'b0;
            buf_pc_q      <= '0;
            buf_insn_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_insn_q    <= out_insn_d;
            buf_valid_q   <= buf_valid_d;
            buf_pc_q      <= buf_pc_d;
            buf_insn_q    <= buf_insn_d;
        end
    end
endmodule
